// File: rtl/maze_pkg.sv
// Shared definitions for the maze game-control slice: game states, map
// geometry and the block-index helper used for move legality.
package maze_pkg;

    typedef enum logic [1:0] {
        ST_WELCOME = 2'd0,
        ST_MAP     = 2'd1,
        ST_WIN     = 2'd2
    } game_state_e;

    localparam int MAX_NUM  = 19;
    localparam int MAP_BITS = 361;
    localparam int START_X  = 1;
    localparam int START_Y  = 1;

    // Row-major block index; 9 bits covers the largest 19x19 map.
    function automatic logic [8:0] blockIndex(input logic [4:0] x,
                                              input logic [4:0] y,
                                              input logic [4:0] num);
        logic [8:0] xw;
        logic [8:0] yw;
        logic [8:0] nw;
        xw = {4'b0, x};
        yw = {4'b0, y};
        nw = {4'b0, num};
        return yw * nw + xw;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button path: 2-flop synchronizer, stable-count debouncer and a
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic             sync1Q;
    logic             sync2Q;
    logic [CNT_W-1:0] cntQ;
    logic [CNT_W-1:0] cntD;
    logic             levelQ;
    logic             levelD;
    logic             prevQ;
    logic [1:0]       validQ;
    logic             armedQ;
    logic             armedD;

    // The counter only runs while the synchronized level disagrees with the
    // accepted one, so any bounce back restarts the qualification window.
    always_comb begin
        cntD   = cntQ;
        levelD = levelQ;
        if (sync2Q == levelQ) begin
            cntD = '0;
        end else if (cntQ == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            levelD = sync2Q;
            cntD   = '0;
        end else begin
            cntD = cntQ + 1'b1;
        end
        armedD = armedQ | (validQ[1] & ~sync2Q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1Q <= 1'b0;
            sync2Q <= 1'b0;
            cntQ   <= '0;
            levelQ <= 1'b0;
            prevQ  <= 1'b0;
            validQ <= 2'b00;
            armedQ <= 1'b0;
        end else begin
            sync1Q <= btn_i;
            sync2Q <= sync1Q;
            cntQ   <= cntD;
            levelQ <= levelD;
            prevQ  <= levelQ;
            validQ <= {validQ[0], 1'b1};
            armedQ <= armedD;
        end
    end

    // A button held through reset stays disarmed until a real release is seen.
    assign pulse_o = levelQ & ~prevQ & armedQ;

endmodule

// File: rtl/maze_player_ctrl.sv
// Game-control stage ahead of the maze renderer: debounced buttons, the
// welcome/play/win FSM and the one-block-per-press move legality check.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                vga_clk,
    input  logic                rst_sys,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_start,
    input  logic [4:0]          num,
    input  logic [MAP_BITS-1:0] map,
    output logic [1:0]          state,
    output logic [4:0]          x_index,
    output logic [4:0]          y_index,
    output logic [15:0]         step_count,
    output logic                move_pulse
);

    logic [4:0]  btnRaw;
    logic [4:0]  btnPulse;
    logic        upP;
    logic        downP;
    logic        leftP;
    logic        rightP;
    logic        startP;

    game_state_e stateQ;
    logic [4:0]  xQ;
    logic [4:0]  yQ;
    logic [15:0] stepsQ;
    logic        moveQ;

    logic [4:0]  tgtX;
    logic [4:0]  tgtY;
    logic [8:0]  tgtIdx;
    logic        dirValid;
    logic        inBounds;
    logic        moveOk;
    logic        atGoal;
    logic [5:0]  numW;

    assign btnRaw = {btn_start, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_btn (
            .clk_i  (vga_clk),
            .rst_i  (rst_sys),
            .btn_i  (btnRaw[i]),
            .pulse_o(btnPulse[i])
        );
    end

    assign upP    = btnPulse[0];
    assign downP  = btnPulse[1];
    assign leftP  = btnPulse[2];
    assign rightP = btnPulse[3];
    assign startP = btnPulse[4];

    // Bounds are tested before any increment/decrement so the target never wraps.
    always_comb begin
        tgtX     = xQ;
        tgtY     = yQ;
        dirValid = 1'b0;
        inBounds = 1'b0;
        numW     = {1'b0, num};
        if (upP) begin
            dirValid = 1'b1;
            inBounds = (yQ != 5'd0);
            if (inBounds) tgtY = yQ - 5'd1;
        end else if (downP) begin
            dirValid = 1'b1;
            inBounds = (({1'b0, yQ} + 6'd1) < numW);
            if (inBounds) tgtY = yQ + 5'd1;
        end else if (leftP) begin
            dirValid = 1'b1;
            inBounds = (xQ != 5'd0);
            if (inBounds) tgtX = xQ - 5'd1;
        end else if (rightP) begin
            dirValid = 1'b1;
            inBounds = (({1'b0, xQ} + 6'd1) < numW);
            if (inBounds) tgtX = xQ + 5'd1;
        end
        tgtIdx = blockIndex(tgtX, tgtY, num);
        moveOk = dirValid && inBounds && (numW <= 6'(MAX_NUM))
                 && (tgtIdx <= 9'(MAP_BITS - 1)) && map[tgtIdx];
        atGoal = (xQ == (num - 5'd2)) && (yQ == (num - 5'd2));
    end

    // Start outranks everything, including a win detected in the same cycle.
    always_ff @(posedge vga_clk) begin
        if (rst_sys) begin
            stateQ <= ST_WELCOME;
            xQ     <= 5'(START_X);
            yQ     <= 5'(START_Y);
            stepsQ <= 16'd0;
            moveQ  <= 1'b0;
        end else begin
            moveQ <= 1'b0;
            case (stateQ)
                ST_WELCOME: begin
                    if (startP) begin
                        stateQ <= ST_MAP;
                        xQ     <= 5'(START_X);
                        yQ     <= 5'(START_Y);
                        stepsQ <= 16'd0;
                    end
                end
                ST_MAP: begin
                    if (startP) begin
                        xQ     <= 5'(START_X);
                        yQ     <= 5'(START_Y);
                        stepsQ <= 16'd0;
                    end else if (atGoal) begin
                        stateQ <= ST_WIN;
                    end else if (moveOk) begin
                        xQ     <= tgtX;
                        yQ     <= tgtY;
                        stepsQ <= (stepsQ == 16'hFFFF) ? stepsQ : stepsQ + 16'd1;
                        moveQ  <= 1'b1;
                    end
                end
                ST_WIN: begin
                    if (startP) stateQ <= ST_WELCOME;
                end
                default: stateQ <= ST_WELCOME;
            endcase
        end
    end

    assign state      = stateQ;
    assign x_index    = xQ;
    assign y_index    = yQ;
    assign step_count = stepsQ;
    assign move_pulse = moveQ;

endmodule
